// File: rtl/secuenciador_contador.sv
// Command sequencer for the cascaded mode counter: runs one up/down/down-by-3/load
// command over a valid/ready handshake and reports the final count and wrap status.
module secuenciador_contador #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [1:0]    CMD_OP,
    input  logic [W-1:0]  CMD_DATO,
    input  logic [CW-1:0] CMD_PASOS,
    output logic          ENB,
    output logic [1:0]    MODO,
    output logic [W-1:0]  D,
    input  logic [W-1:0]  Q,
    input  logic          RCO,
    output logic          BUSY,
    output logic          DONE,
    output logic [W-1:0]  RESULTADO,
    output logic          WRAP
);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, FIN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   dato_q, dato_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic           acc_q, acc_d;
    logic           first_q, first_d;
    logic           done_q, done_d;
    logic [W-1:0]   res_q, res_d;
    logic           wrap_q, wrap_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dato_d  = dato_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        first_d = first_q;
        done_d  = 1'b0;
        res_d   = res_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP;
                    dato_d  = CMD_DATO;
                    rem_d   = CMD_PASOS;
                    acc_d   = 1'b0;
                    first_d = 1'b1;
                    if (CMD_OP == 2'b11)
                        state_d = LOAD;
                    else if (CMD_PASOS != '0)
                        state_d = COUNT;
                    else
                        state_d = FIN;
                end
            end
            LOAD: state_d = FIN;
            COUNT: begin
                // RCO seen in the first count cycle reflects the previous command's last update
                if (!first_q)
                    acc_d = acc_q | RCO;
                first_d = 1'b0;
                if (rem_q == CW'(1))
                    state_d = FIN;
                else
                    rem_d = rem_q - CW'(1);
            end
            FIN: begin
                acc_d   = acc_q | RCO;
                res_d   = Q;
                wrap_d  = acc_q | RCO;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            dato_q  <= '0;
            rem_q   <= '0;
            acc_q   <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dato_q  <= dato_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            done_q  <= done_d;
            res_q   <= res_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        CMD_READY = (state_q == IDLE);
        BUSY      = !CMD_READY;
        ENB       = (state_q == LOAD) || (state_q == COUNT);
        MODO      = (state_q == COUNT) ? op_q : 2'b11;
        D         = (state_q == LOAD) ? dato_q : '0;
        DONE      = done_q;
        RESULTADO = res_q;
        WRAP      = wrap_q;
    end

endmodule

// File: tb/tb_secuenciador_contador.sv
// Scoreboard bench for secuenciador_contador driving a behavioural model of the mode counter.
module tb_secuenciador_contador;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [15:0] CMD_DATO;
    logic [7:0]  CMD_PASOS;
    logic        ENB;
    logic [1:0]  MODO;
    logic [15:0] D;
    logic [15:0] Q;
    logic        RCO;
    logic        BUSY;
    logic        DONE;
    logic [15:0] RESULTADO;
    logic        WRAP;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        wrap;
        int          enb;
        int          lat;
        logic [1:0]  modo;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];

    secuenciador_contador #(.W(16), .CW(8)) dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATO(CMD_DATO), .CMD_PASOS(CMD_PASOS),
        .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO), .BUSY(BUSY),
        .DONE(DONE), .RESULTADO(RESULTADO), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    // counter model: RCO is a registered one-cycle flag after a wrapping update
    logic [15:0] q_m = '0;
    logic        rco_m = 1'b0;
    assign Q   = q_m;
    assign RCO = rco_m;
    always @(posedge CLK) begin
        if (ENB) begin
            case (MODO)
                2'b00: begin q_m <= q_m + 16'd1; rco_m <= (q_m == 16'hFFFF); end
                2'b01: begin q_m <= q_m - 16'd1; rco_m <= (q_m == 16'h0000); end
                2'b10: begin q_m <= q_m - 16'd3; rco_m <= (q_m < 16'd3); end
                default: begin q_m <= D; rco_m <= 1'b0; end
            endcase
        end else begin
            rco_m <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // monitor: counts ENB cycles and latency per command, pops on DONE
    int enb_cnt = 0;
    int lat = 0;
    always @(negedge CLK) begin
        if (!RESET) begin
            lat++;
            if (ENB) begin
                enb_cnt++;
                if (sb.size() == 0) begin
                    chk("enb_without_command", 32'(ENB), 32'd0);
                end else begin
                    chk("modo", 32'(MODO), 32'(sb[0].modo));
                    chk("d", 32'(D), 32'(sb[0].d));
                end
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(DONE), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resultado", 32'(RESULTADO), 32'(e.res));
                    chk("wrap", 32'(WRAP), 32'(e.wrap));
                    chk("enb_cycles", 32'(enb_cnt), 32'(e.enb));
                    chk("done_latency", 32'(lat), 32'(e.lat));
                    chk("ready_in_done", 32'(CMD_READY), 32'd1);
                end
            end
            if (CMD_VALID && CMD_READY) begin
                lat = 0;
                enb_cnt = 0;
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_enb", 32'(ENB), 32'd0);
        chk("rst_modo", 32'(MODO), 32'd3);
        chk("rst_d", 32'(D), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_wrap", 32'(WRAP), 32'd0);
        chk("rst_resultado", 32'(RESULTADO), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() != 0) chk("timeout_done", 32'(sb.size()), 32'd0);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] dato, input logic [7:0] pasos,
                         input logic [15:0] eres, input logic ewrap, input int eenb, input int elat,
                         input bit hold, input bit wait_done);
        exp_t e;
        int n = 0;
        e.res = eres; e.wrap = ewrap; e.enb = eenb; e.lat = elat;
        e.modo = op;
        e.d = (op == 2'b11) ? dato : 16'h0000;
        CMD_VALID = 1'b1;
        CMD_OP = op;
        CMD_DATO = dato;
        CMD_PASOS = pasos;
        do begin
            @(negedge CLK);
            n++;
        end while (!CMD_READY && n < 300);
        if (!CMD_READY) chk("timeout_ready", 32'(CMD_READY), 32'd1);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (!hold) CMD_VALID = 1'b0;
        if (wait_done) wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        RESET = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP = 2'b00;
        CMD_DATO = '0;
        CMD_PASOS = '0;
        #13;
        check_reset_state();
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;

        issue(2'b11, 16'h1234, 8'd0, 16'h1234, 1'b0, 1, 3, 1'b0, 1'b1);
        issue(2'b11, 16'hFFFE, 8'd0, 16'hFFFE, 1'b0, 1, 3, 1'b0, 1'b1);
        issue(2'b00, 16'h0000, 8'd4, 16'h0002, 1'b1, 4, 6, 1'b0, 1'b1);
        issue(2'b11, 16'h0010, 8'd0, 16'h0010, 1'b0, 1, 3, 1'b0, 1'b1);
        issue(2'b10, 16'h0000, 8'd3, 16'h0007, 1'b0, 3, 5, 1'b0, 1'b1);
        issue(2'b10, 16'h0000, 8'd3, 16'hFFFE, 1'b1, 3, 5, 1'b0, 1'b1);
        issue(2'b11, 16'h00AA, 8'd0, 16'h00AA, 1'b0, 1, 3, 1'b0, 1'b1);
        issue(2'b00, 16'h5555, 8'd0, 16'h00AA, 1'b0, 0, 2, 1'b0, 1'b1);

        // abort a down count after two ENB cycles
        issue(2'b11, 16'h0100, 8'd0, 16'h0100, 1'b0, 1, 3, 1'b0, 1'b1);
        issue(2'b01, 16'h0000, 8'd5, 16'h00FB, 1'b0, 5, 7, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("enb_before_abort", 32'(ENB), 32'd1);
        RESET = 1'b1;
        void'(sb.pop_back());
        #1;
        check_reset_state();
        @(posedge CLK); #1;
        RESET = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("no_done_after_abort", 32'(dones), 32'd0);
        chk("q_after_abort", 32'(Q), 32'h00FE);
        @(posedge CLK); #1;
        issue(2'b00, 16'h0000, 8'd2, 16'h0100, 1'b0, 2, 4, 1'b0, 1'b1);

        // CMD_VALID held high across consecutive commands
        issue(2'b11, 16'h0005, 8'd0, 16'h0005, 1'b0, 1, 3, 1'b1, 1'b0);
        issue(2'b01, 16'h7777, 8'd2, 16'h0003, 1'b0, 2, 4, 1'b1, 1'b0);
        issue(2'b00, 16'h7777, 8'd1, 16'h0004, 1'b0, 1, 3, 1'b1, 1'b0);
        issue(2'b11, 16'hBEEF, 8'd9, 16'hBEEF, 1'b0, 1, 3, 1'b0, 1'b1);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
